// File: rtl/async_fifo_pkg.sv
// Shared constants and types for the async FIFO read-side stream adapter.
package async_fifo_pkg;

    localparam int unsigned DEF_FIFO_DATA_WIDTH = 32;
    localparam int unsigned DEF_BUF_DEPTH       = 2;
    localparam int unsigned DEF_CNT_WIDTH       = 16;

    typedef logic [DEF_FIFO_DATA_WIDTH-1:0] fifo_word_t;

endpackage

// File: rtl/async_fifo_read_stream_adapter_if.sv
// FIFO read channel plus outgoing valid/ready stream, grouped for the adapter.
interface async_fifo_read_stream_adapter_if
    import async_fifo_pkg::*;
#(
    parameter int unsigned FIFO_DATA_WIDTH = DEF_FIFO_DATA_WIDTH,
    parameter int unsigned BUF_DEPTH       = DEF_BUF_DEPTH,
    parameter int unsigned CNT_WIDTH       = DEF_CNT_WIDTH
);

    logic                         rd_enable;
    logic                         read_fifo_pop;
    logic                         read_fifo_empty;
    logic [FIFO_DATA_WIDTH-1:0]   read_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [FIFO_DATA_WIDTH-1:0]   out_data;
    logic [CNT_WIDTH-1:0]         out_count;
    logic [$clog2(BUF_DEPTH):0]   buf_occupancy;

    // Adapter side
    modport master (
        input  rd_enable, read_fifo_empty, read_data, out_ready,
        output read_fifo_pop, out_valid, out_data, out_count, buf_occupancy
    );

    // FIFO / consumer side
    modport slave (
        output rd_enable, read_fifo_empty, read_data, out_ready,
        input  read_fifo_pop, out_valid, out_data, out_count, buf_occupancy
    );

endinterface

// File: rtl/async_fifo_rd_prefetch_buf.sv
// Circular prefetch buffer: storage, wrapping pointers and occupancy.
module async_fifo_rd_prefetch_buf #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enq,
    input  logic [DATA_WIDTH-1:0]    enq_data,
    input  logic                     deq,
    output logic [DATA_WIDTH-1:0]    deq_data,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
    localparam int unsigned OCC_WIDTH = PTR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_WIDTH-1:0]  occ_q, occ_d;

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (enq) begin
            mem_d[wr_ptr_q] = enq_data;
            wr_ptr_d        = wr_ptr_q + PTR_WIDTH'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
        end
        case ({enq, deq})
            2'b10:   occ_d = occ_q + OCC_WIDTH'(1);
            2'b01:   occ_d = occ_q - OCC_WIDTH'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage needs no reset; contents are only visible when occupied
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign deq_data  = mem_q[rd_ptr_q];
    assign occupancy = occ_q;
    assign full      = (occ_q == OCC_WIDTH'(DEPTH));
    assign empty     = (occ_q == '0);

endmodule

// File: rtl/async_fifo_read_stream_adapter.sv
// Pops the async FIFO read channel and re-presents words as a valid/ready stream.
module async_fifo_read_stream_adapter
    import async_fifo_pkg::*;
#(
    parameter int unsigned FIFO_DATA_WIDTH = DEF_FIFO_DATA_WIDTH,
    parameter int unsigned BUF_DEPTH       = DEF_BUF_DEPTH,
    parameter int unsigned CNT_WIDTH       = DEF_CNT_WIDTH
) (
    input  logic                             read_clk,
    input  logic                             read_reset,
    async_fifo_read_stream_adapter_if.master bus
);

    localparam int unsigned OCC_WIDTH = $clog2(BUF_DEPTH) + 1;

    logic                       inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0]       count_q, count_d;
    logic                       buf_empty;
    logic                       buf_full;
    logic [OCC_WIDTH-1:0]       occ;
    logic [FIFO_DATA_WIDTH-1:0] head_data;
    logic                       out_valid_c;
    logic                       deq_c;
    logic                       pop_c;
    logic [OCC_WIDTH:0]         proj_occ_c;

    async_fifo_rd_prefetch_buf #(
        .DATA_WIDTH (FIFO_DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_buf (
        .clk       (read_clk),
        .reset     (read_reset),
        .enq       (inflight_q),
        .enq_data  (bus.read_data),
        .deq       (deq_c),
        .deq_data  (head_data),
        .occupancy (occ),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    // Pop only if the word will still have a slot once this cycle's traffic settles
    always_comb begin
        out_valid_c = !buf_empty;
        deq_c       = out_valid_c && bus.out_ready;
        proj_occ_c  = {1'b0, occ} + (OCC_WIDTH+1)'(inflight_q) - (OCC_WIDTH+1)'(deq_c);
        pop_c       = !read_reset && bus.rd_enable && !bus.read_fifo_empty &&
                      (proj_occ_c < (OCC_WIDTH+1)'(BUF_DEPTH));
        inflight_d  = pop_c;
        count_d     = count_q + CNT_WIDTH'(deq_c);
    end

    // In-flight flag and delivered-word counter
    always_ff @(posedge read_clk) begin
        if (read_reset) begin
            inflight_q <= 1'b0;
            count_q    <= '0;
        end else begin
            inflight_q <= inflight_d;
            count_q    <= count_d;
        end
    end

    assign bus.read_fifo_pop = pop_c;
    assign bus.out_valid     = out_valid_c;
    assign bus.out_data      = head_data;
    assign bus.out_count     = count_q;
    assign bus.buf_occupancy = occ;

    // Protocol checks
    a_no_pop_when_empty: assert property (@(posedge read_clk) disable iff (read_reset)
        pop_c |-> !bus.read_fifo_empty);
    a_no_enq_at_full: assert property (@(posedge read_clk) disable iff (read_reset)
        inflight_q |-> !buf_full);
    a_out_stable: assert property (@(posedge read_clk) disable iff (read_reset)
        (out_valid_c && !bus.out_ready) |=> (out_valid_c && $stable(head_data)));

endmodule
